// File: rtl/pipe_chain.sv
// pipe_chain: lock-step register chain with per-stage stall/flush, output backpressure and bubble counting
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    input  logic [WIDTH-1:0]         in_data_i,
    output logic                     in_ready_o,
    input  logic [DEPTH-1:0]         stall_i,
    input  logic [DEPTH-1:0]         flush_i,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    input  logic                     out_ready_i,
    output logic [DEPTH-1:0]         stage_valid_o,
    output logic [DEPTH*WIDTH-1:0]   stage_data_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0]            hold;
    logic                        acc;
    logic                        bubble;
    logic [CNT_W-1:0]            cnt;
    always_comb begin
        hold = '0;
        acc = vld[DEPTH-1] & ~out_ready_i;
        for (int k = DEPTH-1; k >= 0; k--) begin
            acc = acc | stall_i[k];
            hold[k] = acc;
        end
    end
    assign bubble        = |(hold[DEPTH-2:0] & ~hold[DEPTH-1:1]);
    assign in_ready_o    = ~hold[0];
    assign out_valid_o   = vld[DEPTH-1];
    assign out_data_o    = dat[DEPTH-1];
    assign stage_valid_o = vld;
    assign stage_data_o  = dat;
    assign bubble_cnt_o  = cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
            dat <= '0;
            cnt <= '0;
        end else begin
            if (flush_i[0]) begin
                vld[0] <= 1'b0;
                dat[0] <= '0;
            end else if (!hold[0]) begin
                vld[0] <= in_valid_i;
                dat[0] <= in_valid_i ? in_data_i : '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (flush_i[k]) begin
                    vld[k] <= 1'b0;
                    dat[k] <= '0;
                end else if (!hold[k]) begin
                    vld[k] <= hold[k-1] ? 1'b0 : vld[k-1];
                    dat[k] <= hold[k-1] ? '0 : dat[k-1];
                end
            end
            if (bubble && !(&cnt)) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed plus random stimulus checked against a behavioural stage-array model
module tb_pipe_chain;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic [31:0]  in_data_i = '0;
    logic         in_ready_o, in_ready_s;
    logic [3:0]   stall_i = '0;
    logic [3:0]   flush_i = '0;
    logic         out_valid_o, out_valid_s;
    logic [31:0]  out_data_o, out_data_s;
    logic         out_ready_i = 1'b1;
    logic [3:0]   stage_valid_o, stage_valid_s;
    logic [127:0] stage_data_o, stage_data_s;
    logic [15:0]  bubble_cnt_o;
    logic [1:0]   bubble_cnt_s;

    int total = 0;
    int bad = 0;

    bit          mv [4];
    logic [31:0] md [4];
    int          mcnt = 0;

    always #5 clk_i = ~clk_i;

    pipe_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .stage_valid_o(stage_valid_o), .stage_data_o(stage_data_o), .bubble_cnt_o(bubble_cnt_o)
    );

    pipe_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_s), .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(out_valid_s), .out_data_o(out_data_s), .out_ready_i(out_ready_i),
        .stage_valid_o(stage_valid_s), .stage_data_o(stage_data_s), .bubble_cnt_o(bubble_cnt_s)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A stage is held when it, any later stage, or a blocked output asks to stall.
    function automatic bit held(input int k);
        bit h = mv[3] && !out_ready_i;
        for (int j = k; j < 4; j++) h = h | stall_i[j];
        return h;
    endfunction

    task automatic model_step();
        bit          nv [4];
        logic [31:0] nd [4];
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin mv[k] = 0; md[k] = '0; end
            mcnt = 0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            nv[k] = mv[k];
            nd[k] = md[k];
            if (!held(k)) begin
                if (k == 0) begin
                    nv[k] = in_valid_i;
                    nd[k] = in_valid_i ? in_data_i : 32'h0;
                end else if (held(k-1)) begin
                    nv[k] = 0;
                    nd[k] = '0;
                    mcnt++;
                end else begin
                    nv[k] = mv[k-1];
                    nd[k] = md[k-1];
                end
            end
            if (flush_i[k]) begin nv[k] = 0; nd[k] = '0; end
        end
        for (int k = 0; k < 4; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
    endtask

    task automatic check_all();
        logic [3:0]   ev;
        logic [127:0] ed;
        for (int k = 0; k < 4; k++) begin
            ev[k] = mv[k];
            ed[k*32 +: 32] = md[k];
        end
        chk("stage_valid", 128'(stage_valid_o), 128'(ev));
        chk("stage_data", stage_data_o, ed);
        chk("out_valid", 128'(out_valid_o), 128'(mv[3]));
        chk("out_data", 128'(out_data_o), 128'(md[3]));
        chk("bubble_cnt", 128'(bubble_cnt_o), 128'(mcnt > 65535 ? 65535 : mcnt));
        chk("bubble_sat", 128'(bubble_cnt_s), 128'(mcnt > 3 ? 3 : mcnt));
    endtask

    task automatic tick();
        #1;
        chk("in_ready", 128'(in_ready_o), 128'(!held(0)));
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] held_out;
        int c0;
        @(posedge clk_i);
        #1;
        tick();
        chk("reset_valid", 128'(stage_valid_o), 128'(0));
        chk("reset_cnt", 128'(bubble_cnt_o), 128'(0));
        rst_i = 0;

        // streaming 0x11, 0x22, 0x33
        in_valid_i = 1; in_data_i = 32'h11; tick();
        in_data_i = 32'h22; tick();
        in_data_i = 32'h33; tick();
        in_valid_i = 0; in_data_i = 32'h0; tick();
        chk("stream_11", 128'(out_data_o), 128'(32'h11));
        tick();
        chk("stream_22", 128'(out_data_o), 128'(32'h22));
        tick();
        chk("stream_33", 128'(out_data_o), 128'(32'h33));
        chk("stream_cnt", 128'(bubble_cnt_o), 128'(0));

        // mid stall with a full pipe
        in_valid_i = 1;
        for (int i = 0; i < 4; i++) begin in_data_i = 32'hA0 + 32'(i); tick(); end
        c0 = mcnt;
        stall_i = 4'b0010; in_data_i = 32'hB0;
        #1;
        chk("stall_ready", 128'(in_ready_o), 128'(0));
        tick();
        tick();
        chk("stall_bubbles", 128'(bubble_cnt_o), 128'(c0 + 2));
        stall_i = 4'b0000; tick(); tick(); tick();

        // output backpressure
        out_ready_i = 0; in_data_i = 32'hC0;
        held_out = out_data_o;
        c0 = mcnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable", 128'(out_data_o), 128'(held_out));
        end
        chk("bp_cnt", 128'(bubble_cnt_o), 128'(c0));
        out_ready_i = 1;

        // flush of stages 0-1 on a full pipe
        for (int i = 0; i < 4; i++) begin in_data_i = 32'hD0 + 32'(i); tick(); end
        chk("flush_pre", 128'(stage_valid_o), 128'(4'b1111));
        flush_i = 4'b0011; in_data_i = 32'hE0; tick();
        chk("flush_valid", 128'(stage_valid_o), 128'(4'b1100));
        chk("flush_data", 128'(stage_data_o[63:0]), 128'(0));
        flush_i = 4'b0000;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            in_valid_i = $urandom_range(0, 1) == 1;
            in_data_i = $urandom;
            stall_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            flush_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            out_ready_i = $urandom_range(0, 3) != 0;
            tick();
        end

        // counter saturation then reset
        rst_i = 1; stall_i = 0; flush_i = 0; out_ready_i = 1; tick();
        rst_i = 0; in_valid_i = 1; stall_i = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt", 128'(bubble_cnt_s), 128'(3));
        chk("sat_wide", 128'(bubble_cnt_o), 128'(5));
        rst_i = 1; tick();
        chk("sat_rst_valid", 128'(stage_valid_s), 128'(0));
        chk("sat_rst_cnt", 128'(bubble_cnt_s), 128'(0));
        rst_i = 0; stall_i = 0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, 32, payload bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, 4, number of register stages (>=2); stage 0 is entry, stage DEPTH-1 is output.
REQ-003 SHALL have parameter CNT_W, 16, width of bubble counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port in_valid_i  input  1  entry payload present.
REQ-007 SHALL have port in_data_i  input  WIDTH  entry payload.
REQ-008 SHALL have port in_ready_o  output  1  entry accepted when in_valid_i & in_ready_o.
REQ-009 SHALL have port stall_i  input  DEPTH  per-stage hold request, bit k = stage k.
REQ-010 SHALL have port flush_i  input  DEPTH  per-stage kill, bit k = stage k.
REQ-011 SHALL have port out_valid_o  output  1  valid bit of stage DEPTH-1.
REQ-012 SHALL have port out_data_o  output  WIDTH  data of stage DEPTH-1.
REQ-013 SHALL have port out_ready_i  input  1  consumer accepts output.
REQ-014 SHALL have port stage_valid_o  output  DEPTH  valid bit of every stage.
REQ-015 SHALL have port stage_data_o  output  DEPTH*WIDTH  stage k data at bits [k*WIDTH +: WIDTH].
REQ-016 SHALL have port bubble_cnt_o  output  CNT_W  count of stall-inserted bubbles.

Function
REQ-017 SHALL hold per stage one valid bit and one WIDTH-bit data register; all outputs registered except in_ready_o.
REQ-018 SHALL compute hold[DEPTH-1] = stall_i[DEPTH-1] | (out_valid_o & ~out_ready_i), combinationally.
REQ-019 SHALL compute hold[k] = stall_i[k] | hold[k+1] for k < DEPTH-1 (lock-step; no bubble collapsing).
REQ-020 SHALL drive in_ready_o = ~hold[0], independent of in_valid_i.
REQ-021 SHALL, when hold[0]=0, load stage 0 with {in_valid_i, in_data_i}; data loaded as 0 when in_valid_i=0.
REQ-022 SHALL, when hold[k]=0 and k>0, load stage k from stage k-1 if hold[k-1]=0.
REQ-023 SHALL, when hold[k]=0 and hold[k-1]=1, load stage k with a bubble: valid=0, data=0.
REQ-024 SHALL, when hold[k]=1, keep stage k valid and data unchanged.
REQ-025 SHALL, when flush_i[k]=1, set stage k valid=0 and data=0 at the edge, overriding hold and load.
REQ-026 SHALL let flush of stage k not affect hold computation in the same cycle.
REQ-027 SHALL treat output transfer as out_valid_o & out_ready_i & ~stall_i[DEPTH-1]; out_valid_o=0 with out_ready_i=0 SHALL NOT hold the chain.
REQ-028 SHALL give latency DEPTH edges: payload accepted at edge t appears on out_valid_o/out_data_o after edge t+DEPTH-1, with no holds.
REQ-029 SHALL sustain throughput of one payload per cycle with no holds and out_ready_i=1.
REQ-030 SHALL increment bubble_cnt_o by 1 on each edge where REQ-023 applies (at most one boundary per cycle, since hold is monotone), saturating at 2^CNT_W-1.
REQ-031 SHALL NOT count bubbles caused by in_valid_i=0, flushes or output backpressure.
REQ-032 SHALL, when a bubble boundary and flush_i hit the same stage, apply flush and still count the bubble.

Reset
REQ-033 SHALL, with rst_i=1 at an edge, clear all valid bits, all data registers and bubble_cnt_o to 0, overriding all other inputs.
REQ-034 SHALL, during reset mid-operation, discard all in-flight payloads; in_ready_o SHALL follow REQ-020 from cleared state (1 when stall_i=0).
REQ-035 SHALL need no initial values beyond reset; first edge after rst_i deassert behaves per Function.

Verification
REQ-036 SHALL cover streaming: DEPTH=4, inputs 0x11,0x22,0x33 on consecutive cycles, no holds -> out 0x11 after 4th edge, then 0x22, 0x33 on consecutive cycles, bubble_cnt_o=0.
REQ-037 SHALL cover mid stall: stall_i=4'b0010 for 2 cycles with full pipe -> stages 0-1 frozen, in_ready_o=0, stage 2 receives 2 bubbles, bubble_cnt_o=2, no payload lost or duplicated.
REQ-038 SHALL cover backpressure: out_ready_i=0 with out_valid_o=1 for 3 cycles -> whole chain frozen, out_data_o stable, bubble_cnt_o unchanged.
REQ-039 SHALL cover flush: flush_i=4'b0011 while stages 0-3 valid -> after edge stage_valid_o=4'b1100 (plus new entry per REQ-021 suppressed by flush), stages 0-1 data=0.
REQ-040 SHALL cover saturation and reset: CNT_W=2, 5 stall-bubbles -> bubble_cnt_o=3; then rst_i=1 one edge -> all stage_valid_o=0, bubble_cnt_o=0.
